led_sample_sequencer: RTL

LED_SAMPLE_SEQUENCER -- requirements
Module: led_sample_sequencer

---
 rtl/led_sample_sequencer_pkg.sv | 29 ++
 rtl/led_sample_sequencer_averager.sv | 34 +++
 rtl/led_sample_sequencer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/led_sample_sequencer_pkg.sv
// Shared types and constants for the LED sample sequencer.
// State encoding plus front-end defaults applied at reset.
package led_sample_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RED_SET,
        RED_ACC,
        IR_SET,
        IR_ACC,
        DARK
    } state_t;

    localparam logic [6:0] DC_COMP_DEFAULT  = 7'd64;
    localparam logic [3:0] PGA_GAIN_DEFAULT = 4'd0;

    function automatic logic is_red(input state_t s);
        return (s == RED_SET) || (s == RED_ACC);
    endfunction

    function automatic logic is_ir(input state_t s);
        return (s == IR_SET) || (s == IR_ACC);
    endfunction

    function automatic logic is_acc(input state_t s);
        return (s == RED_ACC) || (s == IR_ACC);
    endfunction

endpackage

// File: rtl/led_sample_sequencer_averager.sv
// Accumulate-and-shift averager over 2^NSAMP_LOG2 ADC samples.
// avg already includes the current sample so it is usable on the last cycle.
module sample_averager #(
    parameter int unsigned NSAMP_LOG2 = 2
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       en,
    input  logic       first,
    input  logic [7:0] adc,
    output logic [7:0] avg
);

    localparam int unsigned AW = 8 + NSAMP_LOG2;

    logic [AW-1:0] acc;
    logic [AW-1:0] acc_sum;

    // first cycle of a window restarts from zero instead of the old total
    assign acc_sum = (first ? '0 : acc) + AW'(adc);
    assign avg     = 8'(acc_sum >> NSAMP_LOG2);

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (flush) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_sum;
        end
    end

endmodule

// File: rtl/led_sample_sequencer.sv
// Frame sequencer: RED and IR LED phases, averaged samples,
// and a single-entry valid/ready output buffer with overrun flag.
module led_sample_sequencer
    import led_sample_sequencer_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned NSAMP_LOG2 = 2,
    parameter int unsigned FRAME_CYC  = 1000
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       cal_done,
    input  logic [6:0] red_dc,
    input  logic [3:0] red_gain,
    input  logic [6:0] ir_dc,
    input  logic [3:0] ir_gain,
    input  logic [7:0] ADC,
    output logic       LED_RED,
    output logic       LED_IR,
    output logic [6:0] DC_Comp,
    output logic [3:0] PGA_Gain,
    output logic [7:0] red_sample,
    output logic [7:0] ir_sample,
    output logic       sample_valid,
    input  logic       sample_ready,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned NSAMP = 1 << NSAMP_LOG2;
    localparam int unsigned PW    = $clog2(SETTLE_CYC + NSAMP + 1);
    localparam int unsigned FW    = $clog2(FRAME_CYC + 1);

    localparam logic [PW-1:0] SET_LAST   = PW'(SETTLE_CYC - 1);
    localparam logic [PW-1:0] ACC_LAST   = PW'(NSAMP - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYC - 1);

    state_t        state;
    state_t        nxt;
    logic [PW-1:0] phase;
    logic [FW-1:0] frame_cnt;

    logic [6:0] sh_red_dc;
    logic [3:0] sh_red_gain;
    logic [6:0] sh_ir_dc;
    logic [3:0] sh_ir_gain;
    logic [6:0] sel_red_dc;
    logic [3:0] sel_red_gain;

    logic       run;
    logic       enter_red;
    logic       acc_on;
    logic       acc_first;
    logic       acc_last;
    logic       red_done;
    logic       load;
    logic       consume;
    logic       flush;
    logic [7:0] avg;
    logic [7:0] red_hold;

    assign run       = enable & cal_done;
    assign enter_red = (nxt == RED_SET) && (state != RED_SET);
    assign acc_on    = run && is_acc(state);
    assign acc_first = acc_on && (phase == '0);
    assign acc_last  = (phase == ACC_LAST);
    assign red_done  = acc_on && (state == RED_ACC) && acc_last;
    assign load      = acc_on && (state == IR_ACC) && acc_last;
    assign consume   = sample_valid & sample_ready;
    assign flush     = (state == IDLE);

    // the frame's RED settings must be on the pins in the entry cycle itself
    assign sel_red_dc   = enter_red ? red_dc   : sh_red_dc;
    assign sel_red_gain = enter_red ? red_gain : sh_red_gain;

    always_comb begin
        nxt = state;
        if (state != IDLE && !run) begin
            nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (run)                     nxt = RED_SET;
                RED_SET: if (phase == SET_LAST)       nxt = RED_ACC;
                RED_ACC: if (acc_last)                nxt = IR_SET;
                IR_SET:  if (phase == SET_LAST)       nxt = IR_ACC;
                IR_ACC:  if (acc_last)                nxt = DARK;
                DARK:    if (frame_cnt >= FRAME_LAST) nxt = RED_SET;
                default:                              nxt = IDLE;
            endcase
        end
    end

    sample_averager #(
        .NSAMP_LOG2(NSAMP_LOG2)
    ) u_avg (
        .CLK   (CLK),
        .rst_n (rst_n),
        .flush (flush),
        .en    (acc_on),
        .first (acc_first),
        .adc   (ADC),
        .avg   (avg)
    );

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            phase        <= '0;
            frame_cnt    <= '0;
            sh_red_dc    <= '0;
            sh_red_gain  <= '0;
            sh_ir_dc     <= '0;
            sh_ir_gain   <= '0;
            red_hold     <= '0;
            LED_RED      <= 1'b0;
            LED_IR       <= 1'b0;
            DC_Comp      <= DC_COMP_DEFAULT;
            PGA_Gain     <= PGA_GAIN_DEFAULT;
            red_sample   <= '0;
            ir_sample    <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state <= nxt;

            if (nxt != state || state == DARK || state == IDLE) begin
                phase <= '0;
            end else begin
                phase <= phase + PW'(1);
            end

            if (enter_red) begin
                frame_cnt <= '0;
            end else if (nxt != IDLE) begin
                frame_cnt <= frame_cnt + FW'(1);
            end

            if (enter_red) begin
                sh_red_dc   <= red_dc;
                sh_red_gain <= red_gain;
                sh_ir_dc    <= ir_dc;
                sh_ir_gain  <= ir_gain;
            end

            LED_RED <= is_red(nxt);
            LED_IR  <= is_ir(nxt);
            busy    <= (nxt != IDLE);

            if (is_red(nxt)) begin
                DC_Comp  <= sel_red_dc;
                PGA_Gain <= sel_red_gain;
            end else if (is_ir(nxt)) begin
                DC_Comp  <= sh_ir_dc;
                PGA_Gain <= sh_ir_gain;
            end

            if (red_done) begin
                red_hold <= avg;
            end

            if (load) begin
                red_sample   <= red_hold;
                ir_sample    <= avg;
                sample_valid <= 1'b1;
                if (sample_valid && !sample_ready) begin
                    overrun <= 1'b1;
                end
            end else if (consume) begin
                sample_valid <= 1'b0;
            end

            if (state == IDLE) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
